data_sram_axil: RTL and testbench

DATA_SRAM_AXIL -- requirements
Module: data_sram_axil

---
 rtl/data_sram_axil_if.sv | 37 +++
 rtl/data_sram_axil.sv | 248 ++++++++++++++++++++++++
 tb/tb_data_sram_axil.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_axil_if.sv
// AXI-Lite style bus bundle for data_sram_axil: independent AR/R and AW/W/B channels
// with byte/half/word sizing on the address channels.
interface data_sram_axil_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [1:0]  arsize;
    logic        arunsigned;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [1:0]  awsize;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    modport slave (
        input  arvalid, araddr, arsize, arunsigned, rready,
        input  awvalid, awaddr, awsize, wvalid, wdata, bready,
        output arready, rvalid, rdata, rresp,
        output awready, wready, bvalid, bresp
    );

    modport master (
        output arvalid, araddr, arsize, arunsigned, rready,
        output awvalid, awaddr, awsize, wvalid, wdata, bready,
        input  arready, rvalid, rdata, rresp,
        input  awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/data_sram_axil.sv
// Word-organised data SRAM behind an AXI-Lite style slave: sized, lane-aligned loads/stores,
// independent read and write FSMs with programmable wait states and SLVERR on bad accesses.
module data_sram_axil #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned WR_LAT      = 0
) (
    input logic               clk,
    input logic               rst_n,
    data_sram_axil_if.slave   io_bus
);
    localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LimitAddr = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {RIdle, RWait, RLoad, RResp} rstate_e;
    typedef enum logic [2:0] {WIdle, WHaveA, WHaveD, WWait, WResp} wstate_e;

    logic [31:0] r_mem [DEPTH_WORDS];

    function automatic logic addr_err(input logic [31:0] addr, input logic [1:0] size);
        logic bad;
        bad = ({1'b0, addr} < {1'b0, BASE_ADDR}) || ({1'b0, addr} >= LimitAddr);
        case (size)
            2'b00:   bad = bad;
            2'b01:   bad = bad | addr[0];
            2'b10:   bad = bad | (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - BASE_ADDR) >> 2;
        return off[IdxW-1:0];
    endfunction

    function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   load_fmt = {{24{~uns & sh[7]}}, sh[7:0]};
            2'b01:   load_fmt = {{16{~uns & sh[15]}}, sh[15:0]};
            default: load_fmt = word;
        endcase
    endfunction

    // ---------------- read channel ----------------
    rstate_e     r_rstate;
    logic [2:0]  r_rcnt;
    logic [31:0] r_araddr;
    logic [1:0]  r_arsize;
    logic        r_arunsigned;
    logic        r_rerr;
    logic [31:0] r_rword;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        w_ar_hs;

    assign w_ar_hs = io_bus.arvalid && r_arready;

    // RLoad is the register stage between the memory sample and the visible response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate     <= RIdle;
            r_rcnt       <= 3'd0;
            r_araddr     <= 32'd0;
            r_arsize     <= 2'b00;
            r_arunsigned <= 1'b0;
            r_rerr       <= 1'b0;
            r_rword      <= 32'd0;
            r_arready    <= 1'b1;
            r_rvalid     <= 1'b0;
            r_rdata      <= 32'd0;
            r_rresp      <= 2'b00;
        end else begin
            case (r_rstate)
                RIdle: begin
                    if (w_ar_hs) begin
                        r_araddr     <= io_bus.araddr;
                        r_arsize     <= io_bus.arsize;
                        r_arunsigned <= io_bus.arunsigned;
                        r_rerr       <= addr_err(io_bus.araddr, io_bus.arsize);
                        r_arready    <= 1'b0;
                        if (RD_LAT == 0) begin
                            r_rword  <= r_mem[word_idx(io_bus.araddr)];
                            r_rstate <= RLoad;
                        end else begin
                            r_rcnt   <= 3'(RD_LAT - 1);
                            r_rstate <= RWait;
                        end
                    end
                end
                RWait: begin
                    if (r_rcnt == 3'd0) begin
                        r_rword  <= r_mem[word_idx(r_araddr)];
                        r_rstate <= RLoad;
                    end else begin
                        r_rcnt <= r_rcnt - 3'd1;
                    end
                end
                RLoad: begin
                    r_rvalid <= 1'b1;
                    r_rresp  <= r_rerr ? 2'b10 : 2'b00;
                    r_rdata  <= r_rerr ? 32'd0
                                       : load_fmt(r_rword, r_araddr[1:0], r_arsize, r_arunsigned);
                    r_rstate <= RResp;
                end
                RResp: begin
                    if (io_bus.rready) begin
                        r_rvalid  <= 1'b0;
                        r_rdata   <= 32'd0;
                        r_rresp   <= 2'b00;
                        r_arready <= 1'b1;
                        r_rstate  <= RIdle;
                    end
                end
                default: r_rstate <= RIdle;
            endcase
        end
    end

    assign io_bus.arready = r_arready;
    assign io_bus.rvalid  = r_rvalid;
    assign io_bus.rdata   = r_rdata;
    assign io_bus.rresp   = r_rresp;

    // ---------------- write channel ----------------
    wstate_e     r_wstate;
    logic [2:0]  r_wcnt;
    logic [31:0] r_awaddr;
    logic [1:0]  r_awsize;
    logic [31:0] r_wdata;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_werr;
    logic        w_commit;
    logic [3:0]  w_wbe;
    logic [31:0] w_wbytes;

    assign w_aw_hs  = io_bus.awvalid && r_awready;
    assign w_w_hs   = io_bus.wvalid && r_wready;
    assign w_werr   = addr_err(r_awaddr, r_awsize);
    assign w_commit = (r_wstate == WWait) && (r_wcnt == 3'd0) && !w_werr;

    always_comb begin
        w_wbe = 4'b0000;
        case (r_awsize)
            2'b00:   w_wbe = 4'b0001 << r_awaddr[1:0];
            2'b01:   w_wbe = 4'b0011 << r_awaddr[1:0];
            2'b10:   w_wbe = 4'b1111;
            default: w_wbe = 4'b0000;
        endcase
        w_wbytes = r_wdata << {r_awaddr[1:0], 3'b000};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= WIdle;
            r_wcnt    <= 3'd0;
            r_awaddr  <= 32'd0;
            r_awsize  <= 2'b00;
            r_wdata   <= 32'd0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            // Ready is only high while the matching half is not yet held, so latching is safe.
            if (w_aw_hs) begin
                r_awaddr  <= io_bus.awaddr;
                r_awsize  <= io_bus.awsize;
                r_awready <= 1'b0;
            end
            if (w_w_hs) begin
                r_wdata  <= io_bus.wdata;
                r_wready <= 1'b0;
            end
            case (r_wstate)
                WIdle: begin
                    if (w_aw_hs && w_w_hs) begin
                        r_wcnt   <= 3'(WR_LAT);
                        r_wstate <= WWait;
                    end else if (w_aw_hs) begin
                        r_wstate <= WHaveA;
                    end else if (w_w_hs) begin
                        r_wstate <= WHaveD;
                    end
                end
                WHaveA: begin
                    if (w_w_hs) begin
                        r_wcnt   <= 3'(WR_LAT);
                        r_wstate <= WWait;
                    end
                end
                WHaveD: begin
                    if (w_aw_hs) begin
                        r_wcnt   <= 3'(WR_LAT);
                        r_wstate <= WWait;
                    end
                end
                WWait: begin
                    if (r_wcnt == 3'd0) begin
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_werr ? 2'b10 : 2'b00;
                        r_wstate <= WResp;
                    end else begin
                        r_wcnt <= r_wcnt - 3'd1;
                    end
                end
                WResp: begin
                    if (io_bus.bready) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= 2'b00;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= WIdle;
                    end
                end
                default: r_wstate <= WIdle;
            endcase
        end
    end

    // Storage is never reset; only the addressed byte lanes are written.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wbe[i]) begin
                    r_mem[word_idx(r_awaddr)][8*i +: 8] <= w_wbytes[8*i +: 8];
                end
            end
        end
    end

    assign io_bus.awready = r_awready;
    assign io_bus.wready  = r_wready;
    assign io_bus.bvalid  = r_bvalid;
    assign io_bus.bresp   = r_bresp;
endmodule

// File: tb/tb_data_sram_axil.sv
// Directed bench for data_sram_axil (RD_LAT=1, WR_LAT=3, 64 words): sized loads/stores,
// error responses, back-pressure, same-edge write/read ordering and mid-transaction reset.
module tb_data_sram_axil;
    localparam logic [1:0] SzB = 2'b00;
    localparam logic [1:0] SzH = 2'b01;
    localparam logic [1:0] SzW = 2'b10;
    localparam logic [1:0] Ok  = 2'b00;
    localparam logic [1:0] Err = 2'b10;

    logic clk;
    logic rst_n;
    int   passed = 0;
    int   failed = 0;

    data_sram_axil_if bus ();

    data_sram_axil #(
        .DEPTH_WORDS(64),
        .BASE_ADDR  (32'h8000_0000),
        .RD_LAT     (1),
        .WR_LAT     (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/arready"}, 32'(bus.arready), 32'd1);
        check({tag, "/awready"}, 32'(bus.awready), 32'd1);
        check({tag, "/wready"},  32'(bus.wready),  32'd1);
        check({tag, "/rvalid"},  32'(bus.rvalid),  32'd0);
        check({tag, "/bvalid"},  32'(bus.bvalid),  32'd0);
        check({tag, "/rdata"},   bus.rdata,        32'd0);
        check({tag, "/rresp"},   32'(bus.rresp),   32'd0);
        check({tag, "/bresp"},   32'(bus.bresp),   32'd0);
    endtask

    // Read with rready held low for `stall` cycles after rvalid; expects rvalid 2 edges after AR.
    task automatic rd(input string tag, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                      input int stall);
        int n;
        n = 0;
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arsize = size; bus.arunsigned = uns;
        while (!bus.arready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.arvalid = 1'b0; bus.araddr = ~addr; bus.arsize = 2'b11; bus.arunsigned = ~uns;
        n = 0;
        while (!bus.rvalid && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, "/rlat"}, 32'(n), 32'd2);
        for (int i = 0; i < stall; i++) begin
            check({tag, "/hold_rvalid"},  32'(bus.rvalid),  32'd1);
            check({tag, "/hold_rdata"},   bus.rdata,        exp_data);
            check({tag, "/hold_rresp"},   32'(bus.rresp),   32'(exp_resp));
            check({tag, "/hold_arready"}, 32'(bus.arready), 32'd0);
            @(posedge clk); #1;
        end
        check({tag, "/rdata"}, bus.rdata, exp_data);
        check({tag, "/rresp"}, 32'(bus.rresp), 32'(exp_resp));
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        check({tag, "/arready_after"}, 32'(bus.arready), 32'd1);
    endtask

    // Write: W handshakes first; AW follows `wgap` edges later (0 = same edge).
    task automatic wr(input string tag, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] data, input int wgap, input logic [1:0] exp_resp,
                      input int stall);
        int n;
        bus.wvalid = 1'b1; bus.wdata = data;
        if (wgap == 0) begin
            bus.awvalid = 1'b1; bus.awaddr = addr; bus.awsize = size;
        end
        @(posedge clk); #1;
        bus.wvalid = 1'b0; bus.wdata = ~data;
        if (wgap == 0) begin
            bus.awvalid = 1'b0; bus.awaddr = ~addr; bus.awsize = 2'b11;
        end else begin
            check({tag, "/wready_held"},   32'(bus.wready),  32'd0);
            check({tag, "/awready_empty"}, 32'(bus.awready), 32'd1);
            repeat (wgap - 1) @(posedge clk);
            #1;
            bus.awvalid = 1'b1; bus.awaddr = addr; bus.awsize = size;
            @(posedge clk); #1;
            bus.awvalid = 1'b0; bus.awaddr = ~addr; bus.awsize = 2'b11;
        end
        n = 0;
        while (!bus.bvalid && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, "/blat"}, 32'(n), 32'd4);
        for (int i = 0; i < stall; i++) begin
            check({tag, "/hold_bvalid"},  32'(bus.bvalid),  32'd1);
            check({tag, "/hold_bresp"},   32'(bus.bresp),   32'(exp_resp));
            check({tag, "/hold_awready"}, 32'(bus.awready), 32'd0);
            @(posedge clk); #1;
        end
        check({tag, "/bresp"}, 32'(bus.bresp), 32'(exp_resp));
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    initial begin
        logic seen_b;
        logic seen_r;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arsize = '0; bus.arunsigned = 1'b0;
        bus.rready  = 1'b0;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awsize = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.bready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Byte loads with sign/zero extension of a stored word
        wr("w_deadbeef", 32'h8000_0010, SzW, 32'hDEAD_BEEF, 0, Ok, 0);
        rd("rb_signed",   32'h8000_0013, SzB, 1'b0, 32'hFFFF_FFDE, Ok, 0);
        rd("rb_unsigned", 32'h8000_0013, SzB, 1'b1, 32'h0000_00DE, Ok, 0);
        rd("rw_uns_ign",  32'h8000_0010, SzW, 1'b1, 32'hDEAD_BEEF, Ok, 0);

        // Half store with W leading AW by 3 cycles; upper wdata bits must be ignored
        wr("wh_w_first", 32'h8000_0012, SzH, 32'hABCD_1234, 3, Ok, 0);
        rd("rw_after_h", 32'h8000_0010, SzW, 1'b0, 32'h1234_BEEF, Ok, 0);
        rd("rh_lo_sgn",  32'h8000_0010, SzH, 1'b0, 32'hFFFF_BEEF, Ok, 0);
        rd("rb_1_uns",   32'h8000_0011, SzB, 1'b1, 32'h0000_00BE, Ok, 0);
        rd("rh_hi_sgn",  32'h8000_0012, SzH, 1'b0, 32'h0000_1234, Ok, 0);
        wr("wb_lane1",   32'h8000_0011, SzB, 32'hFFFF_FF77, 0, Ok, 0);
        rd("rw_after_b", 32'h8000_0010, SzW, 1'b0, 32'h1234_77EF, Ok, 0);

        // Error responses; the wrapped indices of the bad addresses must stay untouched
        wr("w_first",    32'h8000_0000, SzW, 32'h1111_1111, 0, Ok, 0);
        wr("w_last",     32'h8000_00FC, SzW, 32'h2222_2222, 0, Ok, 0);
        rd("rh_misalgn", 32'h8000_0011, SzH, 1'b0, 32'h0, Err, 0);
        rd("r_size11",   32'h8000_0010, 2'b11, 1'b0, 32'h0, Err, 0);
        rd("r_above",    32'h8000_0100, SzW, 1'b0, 32'h0, Err, 0);
        rd("r_below",    32'h7FFF_FFFC, SzW, 1'b0, 32'h0, Err, 0);
        wr("w_below",    32'h7FFF_FFFC, SzW, 32'hCAFE_F00D, 0, Err, 0);
        wr("w_above",    32'h8000_0100, SzW, 32'hCAFE_F00D, 0, Err, 0);
        wr("w_misalgn",  32'h8000_0012, SzW, 32'hCAFE_F00D, 0, Err, 0);
        wr("wh_misalgn", 32'h8000_0013, SzH, 32'hCAFE_F00D, 0, Err, 0);
        rd("r_first",    32'h8000_0000, SzW, 1'b0, 32'h1111_1111, Ok, 0);
        rd("r_last",     32'h8000_00FC, SzW, 1'b0, 32'h2222_2222, Ok, 0);
        rd("r_unchg",    32'h8000_0010, SzW, 1'b0, 32'h1234_77EF, Ok, 0);

        // Back-pressure on R and B
        rd("r_stall", 32'h8000_0010, SzW, 1'b0, 32'h1234_77EF, Ok, 5);
        wr("w_stall", 32'h8000_0004, SzW, 32'hA5A5_A5A5, 0, Ok, 5);
        rd("r_stalled_w", 32'h8000_0004, SzW, 1'b0, 32'hA5A5_A5A5, Ok, 0);

        // Write commits at L+4; read handshaked at L+3 samples on that same edge
        wr("w_old", 32'h8000_0020, SzW, 32'h0BAD_F00D, 0, Ok, 0);
        bus.awvalid = 1'b1; bus.awaddr = 32'h8000_0020; bus.awsize = SzW;
        bus.wvalid  = 1'b1; bus.wdata  = 32'h600D_CAFE;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.arvalid = 1'b1; bus.araddr = 32'h8000_0020; bus.arsize = SzW; bus.arunsigned = 1'b0;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        check("same_edge/bvalid_early", 32'(bus.bvalid), 32'd0);
        @(posedge clk); #1;
        check("same_edge/bvalid", 32'(bus.bvalid), 32'd1);
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        check("same_edge/rvalid", 32'(bus.rvalid), 32'd1);
        check("same_edge/old_data", bus.rdata, 32'h0BAD_F00D);
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        rd("same_edge/new_data", 32'h8000_0020, SzW, 1'b0, 32'h600D_CAFE, Ok, 0);

        // Reset one cycle after AW+W (and AR) handshakes: nothing commits or responds
        wr("w_pre_rst", 32'h8000_0030, SzW, 32'h1357_9BDF, 0, Ok, 0);
        bus.awvalid = 1'b1; bus.awaddr = 32'h8000_0030; bus.awsize = SzW;
        bus.wvalid  = 1'b1; bus.wdata  = 32'hFFFF_FFFF;
        bus.arvalid = 1'b1; bus.araddr = 32'h8000_0030; bus.arsize = SzW;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("mid_rst/awready_held", 32'(bus.awready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        seen_b = 1'b0;
        seen_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen_b = seen_b | bus.bvalid;
            seen_r = seen_r | bus.rvalid;
        end
        check("mid_rst/no_bvalid", 32'(seen_b), 32'd0);
        check("mid_rst/no_rvalid", 32'(seen_r), 32'd0);
        rd("mid_rst/unchanged", 32'h8000_0030, SzW, 1'b0, 32'h1357_9BDF, Ok, 0);

        $display("%0d/%0d checks passed", passed, passed + failed);
        $finish;
    end
endmodule
